legv8_instr_encoder: RTL
========================

// Module: legv8_instr_encoder
// PURPOSE
//  Packs LEGv8 D/I/CB/B fields (opcode, registers, 64-bit signed immediate) into 32-bit instruction words.
//  It is the inverse of the pipeline's immediate sign-extender: feeding out_instr back through it returns in_imm.
//  Sits between the test/boot loader and instruction memory.
//  Two-stage valid/ready pipeline with range and format-consistency checking.
// PARAMETERS
//  CNT_W   16  width of the saturating accepted/error counters
// PORTS
//  clk            in   1   sole clock, rising edge
//  reset          in   1   synchronous, active-high
//  in_valid       in   1   request valid
//  in_ready       out  1   request accepted when in_valid & in_ready
//  in_fmt         in   2   0=D, 1=I, 2=CB, 3=B
//  in_opcode      in   11  left-aligned opcode; D uses [10:0], I [10:1], CB [10:3], B [10:5]
//  in_rt          in   5   Rt/Rd field
//  in_rn          in   5   Rn field (ignored for CB/B)
//  in_imm         in   64  signed immediate/offset (word offset for CB/B)
//  out_valid      out  1   encoded word valid
//  out_ready      in   1   downstream accepts when out_valid & out_ready
//  out_instr      out  32  encoded instruction
//  out_range_err  out  1   in_imm did not fit the field (qualified by out_valid)
//  out_fmt_err    out  1   opcode would decode to a different format (qualified by out_valid)
//  acc_count      out  CNT_W  requests accepted since reset, saturating
//  err_count      out  CNT_W  requests with any error since reset, saturating
// BEHAVIOUR
//  - Reset: s1/s2 valid=0, out_valid=0, out_instr=0, both err flags=0, counters=0; in_ready=1 the cycle after reset deasserts.
//  - In reset, in-flight words are discarded. A handshake with reset high is ignored.
//  - S1 registers the request. S2 holds the encoded result and drives the out_* ports.
//  - Latency: accept in cycle N -> out_valid in cycle N+2 with no stall.
//  - Throughput is 1 word/cycle; order is preserved.
//  - Stall rules: s2 advances when !s2_valid | out_ready; s1 advances when s2 advances or !s1_valid.
//  - in_ready = !s1_valid | s2 advances. It is combinational from out_ready.
//  - Outputs stay stable while out_valid & !out_ready.
//  - Field layout:
//    - D:  [31:21]=op, [20:12]=imm[8:0], [11:10]=00, [9:5]=rn, [4:0]=rt
//    - I:  [31:22]=op[10:1], [21:10]=imm[11:0], [9:5]=rn, [4:0]=rt
//    - CB: [31:24]=op[10:3], [23:5]=imm[18:0], [4:0]=rt
//    - B:  [31:26]=op[10:5], [25:0]=imm[25:0]
//  - Range check: in_imm must equal the sign-extension of its low K bits, with K = 9/12/19/26 for D/I/CB/B.
//  - Format check, computed on the assembled word:
//    - B requires [31:26]=000101.
//    - CB requires [31:24]=10110100.
//    - I requires [31:22] in {1001000100, 1001001000, 1011001000, 1101000100}.
//    - D requires that none of the above match.
//  - Counters: acc_count increments on each input handshake.
//  - err_count increments when a word with any error leaves S2.
//  - err_count also increments when such a word is dropped (see CONFIGURATION).
//  - Both counters saturate at all-ones and never wrap.
//  - Simultaneous accept and emit in the same cycle are legal; a full pipe with out_ready=1 still accepts.
// CONFIGURATION
//  LEGV8_ENC_STRICT_EN
//  - Defined: a word with any error is dropped in S2. It is never presented on out_valid; err_count still increments.
//  - Defined: out_range_err and out_fmt_err tie to 0.
//  - Undefined: the word is emitted truncated, with the matching error flag(s) high for that beat.
// TESTING
//  - B, op=0x0A0, imm=-4 -> out_instr=0x17FFFFFC, no errors, 2 cycles after accept.
//  - I, op=0x488, rt=1, rn=2, imm=5 -> 0x91001441.
//  - D, op=0x7C2, rt=3, rn=4, imm=-8 -> 0xF85F8083; CB, op=0x5A0, rt=9, imm=-1 -> 0xB4FFFFE9.
//  - I, imm=2048 -> out_range_err=1 (non-strict) or no output (strict); err_count=1.
//  - D, op=0x5A0 -> out_fmt_err=1; B, op=0x7C2 -> out_fmt_err=1.
//  - Stream 6 words with out_ready low for cycles 3-5:
//    - in_ready drops once both stages are full.
//    - No loss or duplication; order preserved; acc_count=6.
//  - Assert reset with 2 words in flight -> out_valid=0 next cycle; counters=0; no stale word emitted afterwards.

Source files
------------

// File: rtl/legv8_instr_encoder_if.sv
// Request/response bus of the LEGv8 instruction encoder.
// slave = encoder side, master = loader/bench side.
interface legv8_instr_encoder_if #(
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_fmt;
  logic [10:0]      in_opcode;
  logic [4:0]       in_rt;
  logic [4:0]       in_rn;
  logic [63:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             out_range_err;
  logic             out_fmt_err;
  logic [CNT_W-1:0] acc_count;
  logic [CNT_W-1:0] err_count;

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rt, in_rn, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_range_err, out_fmt_err,
           acc_count, err_count
  );

  modport master (
    output in_valid, in_fmt, in_opcode, in_rt, in_rn, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_range_err, out_fmt_err,
           acc_count, err_count
  );
endinterface

// File: rtl/legv8_instr_encoder.sv
// Two-stage LEGv8 D/I/CB/B instruction packer with range and format checking.
// Optional LEGV8_ENC_STRICT_EN: erroneous words are dropped instead of flagged.
module legv8_instr_encoder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  legv8_instr_encoder_if.slave  bus
);
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned IMM_W   = 64;

  localparam logic [1:0] FMT_D  = 2'd0;
  localparam logic [1:0] FMT_I  = 2'd1;
  localparam logic [1:0] FMT_CB = 2'd2;
  localparam logic [1:0] FMT_B  = 2'd3;

  typedef struct packed {
    logic [1:0]       fmt;
    logic [10:0]      op;
    logic [4:0]       rt;
    logic [4:0]       rn;
    logic [IMM_W-1:0] imm;
  } req_t;

  logic               s1_valid_q, s1_valid_d;
  req_t               s1_q, s1_d;
  logic               s2_valid_q, s2_valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   err_q, err_d;
`ifndef LEGV8_ENC_STRICT_EN
  logic               range_q, range_d;
  logic               fmt_q, fmt_d;
`endif

  logic               s2_adv_c, in_ready_c, in_hs_c, err_evt_c;
  logic [INSTR_W-1:0] word_c;
  logic               range_err_c, fmt_err_c;
  logic               is_b_c, is_cb_c, is_i_c;

  // in_ready looks through S2, so it is combinational from out_ready
  assign s2_adv_c   = ~s2_valid_q | bus.out_ready;
  assign in_ready_c = ~s1_valid_q | s2_adv_c;
  assign in_hs_c    = bus.in_valid & in_ready_c;

  // Field packing and range check of the S1 request
  always_comb begin
    word_c      = '0;
    range_err_c = 1'b0;
    unique case (s1_q.fmt)
      FMT_D: begin
        word_c      = {s1_q.op, s1_q.imm[8:0], 2'b00, s1_q.rn, s1_q.rt};
        range_err_c = s1_q.imm != {{55{s1_q.imm[8]}}, s1_q.imm[8:0]};
      end
      FMT_I: begin
        word_c      = {s1_q.op[10:1], s1_q.imm[11:0], s1_q.rn, s1_q.rt};
        range_err_c = s1_q.imm != {{52{s1_q.imm[11]}}, s1_q.imm[11:0]};
      end
      FMT_CB: begin
        word_c      = {s1_q.op[10:3], s1_q.imm[18:0], s1_q.rt};
        range_err_c = s1_q.imm != {{45{s1_q.imm[18]}}, s1_q.imm[18:0]};
      end
      default: begin
        word_c      = {s1_q.op[10:5], s1_q.imm[25:0]};
        range_err_c = s1_q.imm != {{38{s1_q.imm[25]}}, s1_q.imm[25:0]};
      end
    endcase
  end

  // Format consistency: the assembled word must decode back to the requested format
  assign is_b_c  = word_c[31:26] == 6'b000101;
  assign is_cb_c = word_c[31:24] == 8'b10110100;
  assign is_i_c  = (word_c[31:22] == 10'b1001000100) || (word_c[31:22] == 10'b1001001000) ||
                   (word_c[31:22] == 10'b1011001000) || (word_c[31:22] == 10'b1101000100);

  always_comb begin
    unique case (s1_q.fmt)
      FMT_B:   fmt_err_c = ~is_b_c;
      FMT_CB:  fmt_err_c = ~is_cb_c;
      FMT_I:   fmt_err_c = ~is_i_c;
      default: fmt_err_c = is_b_c | is_cb_c | is_i_c;
    endcase
  end

`ifdef LEGV8_ENC_STRICT_EN
  logic any_err_c;
  assign any_err_c = range_err_c | fmt_err_c;
  // Errored words die on the S1->S2 transfer and are counted there
  assign err_evt_c = s2_adv_c & s1_valid_q & any_err_c;
`else
  assign err_evt_c = s2_valid_q & bus.out_ready & (range_q | fmt_q);
`endif

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    s2_valid_d = s2_valid_q;
    instr_d    = instr_q;
    acc_d      = acc_q;
    err_d      = err_q;
`ifndef LEGV8_ENC_STRICT_EN
    range_d    = range_q;
    fmt_d      = fmt_q;
`endif
    if (in_ready_c) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_d.fmt = bus.in_fmt;
        s1_d.op  = bus.in_opcode;
        s1_d.rt  = bus.in_rt;
        s1_d.rn  = bus.in_rn;
        s1_d.imm = bus.in_imm;
      end
    end
    if (s2_adv_c) begin
`ifdef LEGV8_ENC_STRICT_EN
      s2_valid_d = s1_valid_q & ~any_err_c;
`else
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        range_d = range_err_c;
        fmt_d   = fmt_err_c;
      end
`endif
      if (s1_valid_q) instr_d = word_c;
    end
    if (in_hs_c && (acc_q != '1)) acc_d = acc_q + CNT_W'(1);
    if (err_evt_c && (err_q != '1)) err_d = err_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      instr_q    <= '0;
      acc_q      <= '0;
      err_q      <= '0;
`ifndef LEGV8_ENC_STRICT_EN
      range_q    <= 1'b0;
      fmt_q      <= 1'b0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      instr_q    <= instr_d;
      acc_q      <= acc_d;
      err_q      <= err_d;
`ifndef LEGV8_ENC_STRICT_EN
      range_q    <= range_d;
      fmt_q      <= fmt_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_instr = instr_q;
  assign bus.acc_count = acc_q;
  assign bus.err_count = err_q;
`ifdef LEGV8_ENC_STRICT_EN
  assign bus.out_range_err = 1'b0;
  assign bus.out_fmt_err   = 1'b0;
`else
  assign bus.out_range_err = range_q;
  assign bus.out_fmt_err   = fmt_q;
`endif
endmodule
